prog_rate_divider: RTL and testbench
====================================

PROG_RATE_DIVIDER -- requirements
Module: prog_rate_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 25, counter and divisor width in bits.
REQ-002 SHALL have parameter DEF_DIV, default 10000000, divisor value after reset.
REQ-003 SHALL have parameter MIN_DIV, default 1000000, lowest divisor reachable by speed_up or load.
REQ-004 SHALL have parameter STEP, default 500000, divisor decrement applied per speed_up pulse.
REQ-005 SHALL have port clkin, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, counting enable.
REQ-008 SHALL have port load, input, 1, one-cycle strobe to load div_in.
REQ-009 SHALL have port div_in, input, CNT_W, new divisor value, sampled only when load=1.
REQ-010 SHALL have port speed_up, input, 1, one-cycle strobe that shortens the period by STEP.
REQ-011 SHALL have port tick, output, 1, registered one-cycle pulse at each period end.
REQ-012 SHALL have port clkout, output, 1, registered square wave toggling at each period end.
REQ-013 SHALL have port div_cur, output, CNT_W, current divisor register.
REQ-014 SHALL have port at_min, output, 1, high when div_cur equals MIN_DIV.

Function
REQ-015 SHALL hold internal count (CNT_W) and div_reg (CNT_W); period is div_reg+1 enabled cycles.
REQ-016 SHALL, when enable=1 and count>=div_reg, set count to 0, assert tick for one cycle and invert clkout.
REQ-017 SHALL, when enable=1 and count<div_reg, increment count by 1, with tick=0.
REQ-018 SHALL, when enable=0, hold count and clkout and drive tick=0.
REQ-019 SHALL, on load=1 and regardless of enable, set div_reg to max(div_in, MIN_DIV), set count to 0, and drive tick=0 with clkout held that cycle.
REQ-020 SHALL, on speed_up=1 with load=0, set div_reg to div_reg-STEP, saturating at MIN_DIV; the check is div_reg < MIN_DIV+STEP, so no underflow occurs.
REQ-021 SHALL leave count unchanged on speed_up; the >= compare guarantees a wrap on the next enabled cycle if count already exceeds the new div_reg.
REQ-022 SHALL give load priority over speed_up when both are asserted in the same cycle.
REQ-023 SHALL, when speed_up coincides with a period end, both emit tick/toggle and update div_reg in that cycle.
REQ-024 SHALL, when load coincides with a period end, let load win: no tick, no toggle.
REQ-025 SHALL derive at_min combinationally from div_reg; all other outputs come from registers.
REQ-026 SHALL ignore speed_up when at_min=1; div_reg stays MIN_DIV.

Reset
REQ-027 SHALL, while resetn=0, asynchronously force count=0, div_reg=DEF_DIV, tick=0 and clkout=0.
REQ-028 SHALL, on reset asserted mid-period, abandon the partial period; the first tick after release comes DEF_DIV+1 enabled cycles later.

Structure
REQ-029 SHALL keep default constants (DEF_DIV, MIN_DIV, STEP for board and simulation builds) in the shared snake_pkg package.
REQ-030 SHALL be a single module with no sub-modules; the saturating-subtract is a local function.

Verification
REQ-031 SHALL cover: DEF_DIV=9, enable=1 for 40 cycles after reset -> tick on cycles 10, 20, 30, 40 and clkout toggling at each.
REQ-032 SHALL cover: enable dropped for 5 cycles at count=4 -> count held at 4, no tick, next tick delayed by exactly 5 cycles.
REQ-033 SHALL cover: MIN_DIV=3, STEP=2, DEF_DIV=9, four speed_up pulses -> div_cur 7, 5, 3, 3, with at_min=1 after the third pulse.
REQ-034 SHALL cover: load with div_in=1 and MIN_DIV=3 -> div_cur=3 and count=0, then ticks every 4 cycles.
REQ-035 SHALL cover: load and speed_up together at a period end with div_in=6 -> div_cur=6, no tick that cycle, next tick 7 cycles later.
REQ-036 SHALL cover: resetn pulsed low asynchronously mid-period -> tick=0, clkout=0 and div_cur=DEF_DIV immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared divider constants for the board build and the fast simulation build.
package snake_pkg;

  localparam int unsigned BoardCntW   = 25;
  localparam int unsigned BoardDefDiv = 10000000;
  localparam int unsigned BoardMinDiv = 1000000;
  localparam int unsigned BoardStep   = 500000;

  localparam int unsigned SimCntW     = 8;
  localparam int unsigned SimDefDiv   = 9;
  localparam int unsigned SimMinDiv   = 3;
  localparam int unsigned SimStep     = 2;

endpackage

// File: rtl/prog_rate_divider.sv
// Programmable rate divider: one tick and a clkout toggle every div_reg+1 enabled cycles,
// with divisor load and a saturating speed-up strobe.
module prog_rate_divider
  import snake_pkg::*;
#(
  parameter int unsigned CNT_W   = BoardCntW,
  parameter int unsigned DEF_DIV = BoardDefDiv,
  parameter int unsigned MIN_DIV = BoardMinDiv,
  parameter int unsigned STEP    = BoardStep
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             speed_up,
  output logic             tick,
  output logic             clkout,
  output logic [CNT_W-1:0] div_cur,
  output logic             at_min
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] Step   = CNT_W'(STEP);
  // One extra bit so MIN_DIV+STEP cannot wrap.
  localparam logic [CNT_W:0]   SatThr = (CNT_W + 1)'(MIN_DIV + STEP);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             clkout_q, clkout_d;

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] d);
    if ({1'b0, d} < SatThr) begin
      return MinDiv;
    end
    return d - Step;
  endfunction

  assign at_min = (div_q == MinDiv);

  always_comb begin
    count_d  = count_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    clkout_d = clkout_q;
    if (load) begin
      div_d   = (div_in < MinDiv) ? MinDiv : div_in;
      count_d = '0;
    end else begin
      if (enable) begin
        if (count_q >= div_q) begin
          count_d  = '0;
          tick_d   = 1'b1;
          clkout_d = ~clkout_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      if (speed_up && !at_min) begin
        div_d = sat_sub(div_q);
      end
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      div_q    <= DefDiv;
      tick_q   <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      clkout_q <= clkout_d;
    end
  end

  assign tick    = tick_q;
  assign clkout  = clkout_q;
  assign div_cur = div_q;

endmodule

// File: tb/tb_prog_rate_divider.sv
// Directed bench for prog_rate_divider with DEF_DIV=9, MIN_DIV=3, STEP=2.
module tb_prog_rate_divider;

  localparam int unsigned W = 8;

  logic         clkin = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         speed_up = 1'b0;
  logic         tick;
  logic         clkout;
  logic [W-1:0] div_cur;
  logic         at_min;

  int errors = 0;
  int checks = 0;

  prog_rate_divider #(
    .CNT_W  (W),
    .DEF_DIV(9),
    .MIN_DIV(3),
    .STEP   (2)
  ) dut (
    .clkin   (clkin),
    .resetn  (resetn),
    .enable  (enable),
    .load    (load),
    .div_in  (div_in),
    .speed_up(speed_up),
    .tick    (tick),
    .clkout  (clkout),
    .div_cur (div_cur),
    .at_min  (at_min)
  );

  always #5 clkin = ~clkin;

  // Advance one rising edge, then settle 1 time unit for sampling and driving.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic do_reset();
    enable   = 1'b0;
    load     = 1'b0;
    speed_up = 1'b0;
    div_in   = '0;
    resetn   = 1'b0;
    cyc(1);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tick !== 1'b0 || clkout !== 1'b0 || div_cur !== 8'd9 || at_min !== 1'b0) begin
      errors++;
      $display("FAIL reset: tick=%b clkout=%b div_cur=%0d at_min=%b, want 0 0 9 0",
               tick, clkout, div_cur, at_min);
    end
  endtask

  task automatic test_free_run();
    logic exp_clk;
    exp_clk = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      if (c % 10 == 0) exp_clk = ~exp_clk;
      checks++;
      if (tick !== (c % 10 == 0) || clkout !== exp_clk) begin
        errors++;
        $display("FAIL free_run cycle %0d: tick=%b clkout=%b, want %b %b",
                 c, tick, clkout, (c % 10 == 0), exp_clk);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    enable = 1'b1;
    cyc(4);
    enable = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc(1);
      checks++;
      if (tick !== 1'b0 || clkout !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold idle %0d: tick=%b clkout=%b, want 0 0", c, tick, clkout);
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc(1);
      checks++;
      if (tick !== (c == 6)) begin
        errors++;
        $display("FAIL enable_hold resume %0d: tick=%b, want %b", c, tick, (c == 6));
      end
    end
  endtask

  task automatic test_speed_up();
    logic [W-1:0] exp_div [4];
    logic         exp_min [4];
    exp_div = '{8'd7, 8'd5, 8'd3, 8'd3};
    exp_min = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      speed_up = 1'b1;
      cyc(1);
      speed_up = 1'b0;
      checks++;
      if (div_cur !== exp_div[p] || at_min !== exp_min[p]) begin
        errors++;
        $display("FAIL speed_up pulse %0d: div_cur=%0d at_min=%b, want %0d %b",
                 p + 1, div_cur, at_min, exp_div[p], exp_min[p]);
      end
    end
  endtask

  task automatic test_speed_at_end();
    do_reset();
    enable = 1'b1;
    cyc(9);
    speed_up = 1'b1;
    cyc(1);
    speed_up = 1'b0;
    checks++;
    if (tick !== 1'b1 || clkout !== 1'b1 || div_cur !== 8'd7) begin
      errors++;
      $display("FAIL speed_at_end: tick=%b clkout=%b div_cur=%0d, want 1 1 7",
               tick, clkout, div_cur);
    end
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      checks++;
      if (tick !== (c == 8)) begin
        errors++;
        $display("FAIL speed_at_end next %0d: tick=%b, want %b", c, tick, (c == 8));
      end
    end
  endtask

  task automatic test_load_min();
    do_reset();
    enable = 1'b1;
    cyc(3);
    load   = 1'b1;
    div_in = 8'd1;
    cyc(1);
    load = 1'b0;
    checks++;
    if (div_cur !== 8'd3 || at_min !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_min: div_cur=%0d at_min=%b tick=%b, want 3 1 0", div_cur, at_min, tick);
    end
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      checks++;
      if (tick !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL load_min period %0d: tick=%b, want %b", c, tick, (c % 4 == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    cyc(9);
    load     = 1'b1;
    speed_up = 1'b1;
    div_in   = 8'd6;
    cyc(1);
    load     = 1'b0;
    speed_up = 1'b0;
    checks++;
    if (div_cur !== 8'd6 || tick !== 1'b0 || clkout !== 1'b0) begin
      errors++;
      $display("FAIL load_speed_end: div_cur=%0d tick=%b clkout=%b, want 6 0 0",
               div_cur, tick, clkout);
    end
    for (int c = 1; c <= 7; c++) begin
      cyc(1);
      checks++;
      if (tick !== (c == 7)) begin
        errors++;
        $display("FAIL load_speed_end next %0d: tick=%b, want %b", c, tick, (c == 7));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    load   = 1'b1;
    div_in = 8'd5;
    cyc(1);
    load = 1'b0;
    cyc(6);
    checks++;
    if (tick !== 1'b1 || clkout !== 1'b1 || div_cur !== 8'd5) begin
      errors++;
      $display("FAIL async_pre: tick=%b clkout=%b div_cur=%0d, want 1 1 5", tick, clkout, div_cur);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0 || clkout !== 1'b0 || div_cur !== 8'd9) begin
      errors++;
      $display("FAIL async_reset: tick=%b clkout=%b div_cur=%0d, want 0 0 9",
               tick, clkout, div_cur);
    end
    #1 resetn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc(1);
      checks++;
      if (tick !== (c == 10)) begin
        errors++;
        $display("FAIL async_release %0d: tick=%b, want %b", c, tick, (c == 10));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_free_run();
    test_enable_hold();
    test_speed_up();
    test_speed_at_end();
    test_load_min();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
